// File: rtl/resonator_dds_mul_pkg.sv
// Shared sizing and pipeline tag type for the resonator DDS multiplier scheduler.
package resonator_dds_mul_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned A_W   = 16;
  localparam int unsigned B_W   = 18;
  localparam int unsigned P_W   = A_W + B_W;
  localparam int unsigned ID_W  = $clog2(N_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/resonator_dds_mul_rr_arb.sv
// Round-robin pick: the first requester at or after i_ptr, wrapping, wins.
module resonator_dds_mul_rr_arb #(
  parameter int unsigned N  = resonator_dds_mul_pkg::N_REQ,
  parameter int unsigned IW = resonator_dds_mul_pkg::ID_W
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_grant
);

  int unsigned w_idx;
  logic        w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (i_en && !w_found && i_req[w_idx[IW-1:0]]) begin
        o_grant[w_idx[IW-1:0]] = 1'b1;
        w_found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/resonator_dds_mul_sched.sv
// Schedules N_REQ requesters onto one external 2-register multiplier and
// tags each product with its requester id so results come back in issue order.
module resonator_dds_mul_sched #(
  parameter int unsigned N_REQ = resonator_dds_mul_pkg::N_REQ,
  parameter int unsigned A_W   = resonator_dds_mul_pkg::A_W,
  parameter int unsigned B_W   = resonator_dds_mul_pkg::B_W,
  parameter int unsigned P_W   = resonator_dds_mul_pkg::P_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*A_W-1:0]     req_a,
  input  logic [N_REQ*B_W-1:0]     req_b,
  output logic                     mul_ce,
  output logic [A_W-1:0]           mul_a,
  output logic [B_W-1:0]           mul_b,
  input  logic [P_W-1:0]           mul_p,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [P_W-1:0]           rsp_p,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic                     busy
);

  import resonator_dds_mul_pkg::*;

  localparam int unsigned IdW = $clog2(N_REQ);

  logic [N_REQ-1:0] w_grant;
  logic             w_en;
  logic             w_xfer;
  logic [IdW-1:0]   w_gid;
  logic [IdW-1:0]   w_ptr_next;
  logic [IdW-1:0]   r_ptr;
  tag_t             r_tag1;
  tag_t             r_tag2;

  // A presented-but-unaccepted result freezes the multiplier and the tags together.
  assign mul_ce = !(r_tag2.valid && !rsp_ready);
  // Reset gating keeps req_ready low while reset_n is held.
  assign w_en   = mul_ce && reset_n;

  resonator_dds_mul_rr_arb #(
    .N  (N_REQ),
    .IW (IdW)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_en),
    .o_grant (w_grant)
  );

  assign req_ready = w_grant;
  assign w_xfer    = |(req_valid & w_grant);

  always_comb begin
    w_gid = '0;
    mul_a = '0;
    mul_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_gid = IdW'(i);
        mul_a = req_a[i*A_W +: A_W];
        mul_b = req_b[i*B_W +: B_W];
      end
    end
  end

  assign w_ptr_next = (w_gid == IdW'(N_REQ - 1)) ? '0 : w_gid + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_ptr  <= '0;
    end else if (mul_ce) begin
      r_tag1.valid <= w_xfer;
      r_tag1.id    <= w_gid;
      r_tag2       <= r_tag1;
      if (w_xfer) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign rsp_valid = r_tag2.valid;
  assign rsp_id    = r_tag2.id;
  assign rsp_p     = mul_p;
  assign busy      = r_tag1.valid || r_tag2.valid;

endmodule

// File: tb/tb_resonator_dds_mul_sched.sv
// Scoreboard bench: issued transfers push expected products; responses pop and compare.
module tb_resonator_dds_mul_sched;

  localparam int NR  = 4;
  localparam int AW  = 16;
  localparam int BW  = 18;
  localparam int PW  = 34;

  logic              clk;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_a;
  logic [NR*BW-1:0]  req_b;
  logic              mul_ce;
  logic [AW-1:0]     mul_a;
  logic [BW-1:0]     mul_b;
  logic [PW-1:0]     mul_p;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [PW-1:0]     rsp_p;
  logic [1:0]        rsp_id;
  logic              busy;

  resonator_dds_mul_sched dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_ce    (mul_ce),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 2-register multiplier: operand registers then product register.
  logic [AW-1:0] m_a;
  logic [BW-1:0] m_b;
  always @(posedge clk) begin
    if (mul_ce) begin
      m_a   <= mul_a;
      m_b   <= mul_b;
      mul_p <= $signed({18'b0, m_a}) * $signed({{16{m_b[BW-1]}}, m_b});
    end
  end

  int vectors;
  int miscompares;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int     id;
    longint p;
    int     age;
  } exp_t;

  exp_t   sb_q[$];
  int     grant_log[$];
  int     mptr;
  int     g;
  int     idx;
  bit     exp_v;
  bit     exp_ce;
  longint ea;
  longint eb;
  exp_t   e;

  // Monitor: reference arbitration and in-flight queue, evaluated once per cycle
  // on the falling edge to predict what the coming rising edge will do.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mul_ce", mul_ce, 1);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      chk("rst_rsp_id", rsp_id, 0);
      sb_q.delete();
      mptr = 0;
    end else begin
      exp_v = (sb_q.size() > 0) && (sb_q[0].age >= 2);
      chk("rsp_valid", rsp_valid, exp_v);
      if (exp_v) begin
        chk("rsp_p", longint'($signed(rsp_p)), sb_q[0].p);
        chk("rsp_id", rsp_id, sb_q[0].id);
      end
      exp_ce = !(exp_v && !rsp_ready);
      chk("mul_ce", mul_ce, exp_ce);
      chk("busy", busy, sb_q.size() > 0);
      g = -1;
      if (exp_ce) begin
        for (int k = 0; k < NR; k++) begin
          idx = (mptr + k) % NR;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      chk("req_ready", req_ready, (g >= 0) ? (longint'(1) << g) : 0);
      if (g >= 0) begin
        ea = longint'(req_a[g*AW +: AW]);
        eb = longint'($signed(req_b[g*BW +: BW]));
        chk("mul_a", mul_a, ea);
        chk("mul_b", longint'($signed(mul_b)), eb);
      end else begin
        chk("mul_a_idle", mul_a, 0);
        chk("mul_b_idle", mul_b, 0);
      end
      if (exp_v && rsp_ready) void'(sb_q.pop_front());
      if (exp_ce) foreach (sb_q[i]) sb_q[i].age++;
      if (g >= 0) begin
        e.id  = g;
        e.p   = ea * eb;
        e.age = 1;
        sb_q.push_back(e);
        grant_log.push_back(g);
        mptr = (g + 1) % NR;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) set_op(i, AW'($urandom), BW'($urandom));
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic chk_log(input string name, input int pos, input int exp);
    chk(name, (grant_log.size() > pos) ? grant_log[pos] : -1, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Single request: 3 * -5 from requester 0.
    grant_log.delete();
    set_op(0, 16'd3, -18'sd5);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk_log("single_grant", 0, 0);

    // All four held valid for 8 cycles from a fresh pointer.
    pulse_reset();
    grant_log.delete();
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    chk("rr_count", grant_log.size(), 8);
    for (int c = 0; c < 8; c++) chk_log("rr_order", c, c % NR);

    // Backpressure with two products in flight, five stalled cycles.
    rand_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    repeat (7) tick();
    rsp_ready = 1'b1;
    repeat (2) tick();
    req_valid = '0;
    repeat (4) tick();

    // Operand extremes.
    set_op(2, 16'hFFFF, 18'h20000);
    req_valid = 4'b0100;
    tick();
    set_op(2, 16'hFFFF, 18'h1FFFF);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Reset with two products in flight; none may surface afterwards.
    rand_ops();
    req_valid = 4'b0011;
    repeat (2) tick();
    req_valid = 4'b1111;
    pulse_reset();
    grant_log.delete();
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk("post_rst_count", grant_log.size(), 1);
    chk_log("post_rst_grant", 0, 0);

    // Pointer holds across an idle cycle.
    grant_log.delete();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b1010;
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk_log("hold_first", 0, 2);
    chk_log("hold_second", 1, 3);

    // Randomised traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      rand_ops();
      req_valid = NR'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) tick();
    chk("drain_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/resonator_dds_mul_sched.md
RESONATOR_DDS_MUL_SCHED -- requirements
Module: resonator_dds_mul_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing the multiplier.
REQ-002 SHALL have parameter A_W, default 16: unsigned operand A width.
REQ-003 SHALL have parameter B_W, default 18: signed operand B width.
REQ-004 SHALL have parameter P_W, default 34: product width, equal to A_W+B_W.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid, input, N_REQ: per-requester operand-pair valid.
REQ-008 SHALL have port req_ready, output, N_REQ: per-requester accept; one-hot or zero.
REQ-009 SHALL have port req_a, input, N_REQ*A_W: packed unsigned operands, requester i at [i*A_W +: A_W].
REQ-010 SHALL have port req_b, input, N_REQ*B_W: packed signed operands.
REQ-011 SHALL have port mul_ce, output, 1: clock enable to the shared 2-register multiplier.
REQ-012 SHALL have ports mul_a (output, A_W) and mul_b (output, B_W): operands to the multiplier.
REQ-013 SHALL have port mul_p, input, P_W: multiplier product; valid 2 enabled edges after operands are presented.
REQ-014 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_p (output, P_W) and rsp_id (output, clog2(N_REQ)): the result stream.
REQ-015 SHALL have port busy, output, 1: high while any product is in flight or presented.

Function
REQ-016 SHALL arbitrate round-robin: highest priority goes to the index after the last granted requester, wrapping from N_REQ-1 to 0.
REQ-017 SHALL grant at most one requester per cycle; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-018 SHALL assert req_ready[i] only for the granted requester and only when mul_ce is high.
REQ-019 SHALL drive mul_a and mul_b combinationally from the granted requester, and drive zero when no grant is made.
REQ-020 SHALL compute mul_ce = NOT(rsp_valid AND NOT rsp_ready); a stall freezes the multiplier and the tag pipeline together.
REQ-021 SHALL carry a {valid, id} tag through two registers enabled by mul_ce, aligned with the multiplier a/b and p registers.
REQ-022 SHALL drive rsp_valid from tag stage 2, rsp_id from the stage-2 id, and rsp_p = mul_p passthrough.
REQ-023 SHALL give a latency of exactly 2 cycles from transfer to rsp_valid when there is no stall, with a sustained throughput of 1 product per cycle.
REQ-024 SHALL hold rsp_valid, rsp_p and rsp_id stable while rsp_valid is high and rsp_ready is low.
REQ-025 SHALL advance the round-robin pointer only on a transfer; an idle cycle or a stall leaves it unchanged.
REQ-026 SHALL keep the pointer unchanged when a requester drops req_valid without transferring, and that requester loses no priority.
REQ-027 SHALL deliver results in issue order; the maximum in-flight count is 2.
REQ-028 SHALL drive busy = stage-1 valid OR stage-2 valid.

Reset
REQ-029 SHALL, on reset_n low, asynchronously clear the tag valids, tag ids and round-robin pointer (pointer = 0, so requester 0 has top priority).
REQ-030 SHALL output during reset: rsp_valid=0, rsp_id=0, req_ready=0, busy=0, mul_ce=1, and mul_a/mul_b=0.
REQ-031 SHALL discard products in flight when reset is asserted mid-operation; none SHALL emerge after release.
REQ-032 SHALL allow a first grant on the first rising edge after reset_n deasserts.

Structure
REQ-033 SHALL place N_REQ, A_W, B_W, P_W, ID_W and the tag struct {valid, id} in the shared package resonator_dds_mul_pkg.
REQ-034 SHALL isolate the round-robin pick in one sub-module, resonator_dds_mul_rr_arb (inputs: request vector, pointer, enable; output: one-hot grant).
REQ-035 SHALL leave the multiplier outside this block; the block connects only through mul_ce, mul_a, mul_b and mul_p.

Verification
REQ-036 SHALL cover a single request: req0 a=3, b=-5, rsp_ready=1 -> rsp_valid 2 cycles later, rsp_p=-15, rsp_id=0.
REQ-037 SHALL cover all 4 requesters held valid for 8 cycles -> grants 0,1,2,3,0,1,2,3 and 8 back-to-back responses in that id order.
REQ-038 SHALL cover backpressure: rsp_ready=0 for 5 cycles with 2 products in flight -> req_ready=0, rsp stable, no loss, correct order on release.
REQ-039 SHALL cover boundaries: a=65535, b=-131072 -> rsp_p=-8589803520; a=65535, b=131071 -> rsp_p=8589737985.
REQ-040 SHALL cover reset mid-flight: reset_n pulsed low with 2 products in flight -> no rsp_valid after release, and the next grant goes to req0.
REQ-041 SHALL cover pointer hold: req2 granted, then an idle cycle, then req1 and req3 requesting -> req3 granted first.
